// File: rtl/i2c_dac_target.sv
// I2C target for an 8-bit DAC register: address match, control byte, data bytes,
// and read-back of the current DAC code. Open-drain sda, no clock stretching.
module i2c_dac_target #(
  parameter logic [6:0] DEVICE_ID = 7'b100_1100,
  parameter logic [7:0] CODE_RST  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] ctrl_byte,
  output logic [7:0] dac_code,
  output logic       dac_code_vld,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SYNC_W = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   scl_q, sda_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic                oe_q, oe_d;
  logic                rw_q, rw_d;
  logic [BYTE_W-1:0]   ctrl_q, ctrl_d;
  logic [BYTE_W-1:0]   code_q, code_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;

  logic                scl_rise_c, scl_fall_c, start_c, stop_c, last_bit_c;
  logic [BYTE_W-1:0]   shift_in_c;

  // Two synchroniser stages plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[SYNC_W-2:0], scl};
      sda_q <= {sda_q[SYNC_W-2:0], sda};
    end
  end

  assign scl_rise_c = scl_q[1] & ~scl_q[2];
  assign scl_fall_c = ~scl_q[1] & scl_q[2];
  assign start_c    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_c     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign shift_in_c = {shift_q[BYTE_W-2:0], sda_q[1]};
  assign last_bit_c = (cnt_q == CNT_W'(7));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      shift_q <= '0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
      ctrl_q  <= '0;
      code_q  <= CODE_RST;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      shift_q <= shift_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
      ctrl_q  <= ctrl_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  // Bus conditions take priority; otherwise bits shift on scl rise, sda changes on scl fall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    shift_d = shift_q;
    oe_d    = oe_q;
    rw_d    = rw_q;
    ctrl_d  = ctrl_q;
    code_d  = code_q;
    vld_d   = 1'b0;
    busy_d  = busy_q;

    if (start_c) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      done_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise_c) begin
            shift_d = shift_in_c;
            cnt_d   = cnt_q + CNT_W'(1);
            done_d  = last_bit_c;
          end else if (scl_fall_c && done_q) begin
            done_d = 1'b0;
            if (shift_q[BYTE_W-1:1] == DEVICE_ID) begin
              state_d = ST_ADDR_ACK;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_c) begin
            if (rw_q) begin
              state_d = ST_TX;
              shift_d = code_q;
              oe_d    = ~code_q[BYTE_W-1];
            end else begin
              state_d = ST_CTRL;
              oe_d    = 1'b0;
            end
          end
        end
        ST_CTRL: begin
          if (scl_rise_c) begin
            shift_d = shift_in_c;
            cnt_d   = cnt_q + CNT_W'(1);
            done_d  = last_bit_c;
            if (last_bit_c) ctrl_d = shift_in_c;
          end else if (scl_fall_c && done_q) begin
            done_d  = 1'b0;
            state_d = ST_CTRL_ACK;
            oe_d    = 1'b1;
          end
        end
        ST_DATA: begin
          if (scl_rise_c) begin
            shift_d = shift_in_c;
            cnt_d   = cnt_q + CNT_W'(1);
            done_d  = last_bit_c;
            if (last_bit_c) begin
              code_d = shift_in_c;
              vld_d  = 1'b1;
            end
          end else if (scl_fall_c && done_q) begin
            done_d  = 1'b0;
            state_d = ST_DATA_ACK;
            oe_d    = 1'b1;
          end
        end
        ST_CTRL_ACK, ST_DATA_ACK: begin
          if (scl_fall_c) begin
            state_d = ST_DATA;
            oe_d    = 1'b0;
          end
        end
        ST_TX: begin
          if (scl_rise_c) begin
            cnt_d  = cnt_q + CNT_W'(1);
            done_d = last_bit_c;
          end else if (scl_fall_c) begin
            if (done_q) begin
              done_d  = 1'b0;
              state_d = ST_TX_ACK;
              oe_d    = 1'b0;
            end else begin
              shift_d = {shift_q[BYTE_W-2:0], 1'b0};
              oe_d    = ~shift_q[BYTE_W-2];
            end
          end
        end
        ST_TX_ACK: begin
          // A NACK ends the read; an ACK means the initiator wants another copy
          if (scl_rise_c && sda_q[1]) begin
            state_d = ST_IGNORE;
          end else if (scl_fall_c) begin
            state_d = ST_TX;
            shift_d = code_q;
            oe_d    = ~code_q[BYTE_W-1];
          end
        end
        ST_IDLE, ST_IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  assign sda          = oe_q ? 1'b0 : 1'bz;
  assign ctrl_byte    = ctrl_q;
  assign dac_code     = code_q;
  assign dac_code_vld = vld_q;
  assign busy         = busy_q;

endmodule
